// File: rtl/cmd_rsp_initiator.sv
// Command/response initiator: issues one command, waits for the response or a timeout,
// and hands the result (with expected-value mismatch flag) back to the user.
module cmd_rsp_initiator #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_payload,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WIDTH-1:0] cmd_payload,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [WIDTH-1:0] rsp_payload,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_payload,
  output logic             res_timeout,
  output logic             res_mismatch,
  output logic             busy,
  output logic [7:0]       txn_count,
  output logic [7:0]       stray_count
);

  // state | meaning
  // IDLE  | waiting for a user request
  // SEND  | presenting the command until the responder takes it
  // WAIT  | waiting for a response, timer running
  // DONE  | presenting the result until the user takes it
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cmd_reg;
  logic [WIDTH-1:0] expected;
  logic [7:0]       timer;
  logic             timer_hit;

  assign expected    = cmd_reg + cmd_reg;
  assign timer_hit   = (timer == TMO);
  assign cmd_payload = cmd_reg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs depend only on state; reset forces them low while asserted.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    rsp_ready = !reset;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_nxt = SEND;
      end
      SEND: begin
        cmd_valid = !reset;
        busy      = !reset;
        if (cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        busy = !reset;
        if (rsp_valid || timer_hit) state_nxt = DONE;
      end
      DONE: begin
        res_valid = !reset;
        busy      = !reset;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_reg      <= '0;
      timer        <= '0;
      res_payload  <= '0;
      res_timeout  <= 1'b0;
      res_mismatch <= 1'b0;
      txn_count    <= '0;
      stray_count  <= '0;
    end else begin
      if (state == IDLE && req_valid) cmd_reg <= req_payload;
      if (state == SEND && cmd_ready) timer <= '0;
      // A response arriving on the timeout cycle wins over the timeout.
      if (state == WAIT) begin
        if (rsp_valid) begin
          res_payload  <= rsp_payload;
          res_timeout  <= 1'b0;
          res_mismatch <= (rsp_payload != expected);
        end else if (timer_hit) begin
          res_payload  <= '0;
          res_timeout  <= 1'b1;
          res_mismatch <= 1'b0;
        end else begin
          timer <= timer + 8'd1;
        end
      end
      if (state == DONE && res_ready) txn_count <= txn_count + 8'd1;
      if (state != WAIT && rsp_valid && stray_count != 8'hFF)
        stray_count <= stray_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmd_rsp_initiator.sv
// Self-checking bench for cmd_rsp_initiator: directed scenarios plus random transactions
// predicted by a transaction-level model (delays in, result and counters out).
module tb_cmd_rsp_initiator;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_payload;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_payload;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_payload;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_payload;
  logic             res_timeout, res_mismatch, busy;
  logic [7:0]       txn_count, stray_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_txn = 0;
  int exp_stray = 0;

  cmd_rsp_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload(cmd_payload),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload),
    .res_valid(res_valid), .res_ready(res_ready), .res_payload(res_payload),
    .res_timeout(res_timeout), .res_mismatch(res_mismatch), .busy(busy),
    .txn_count(txn_count), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic add_stray();
    if (exp_stray < 255) exp_stray++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready, 0);
    chk({tag, ".rsp_ready"}, rsp_ready, 0);
    chk({tag, ".cmd_valid"}, cmd_valid, 0);
    chk({tag, ".cmd_payload"}, cmd_payload, 0);
    chk({tag, ".res_valid"}, res_valid, 0);
    chk({tag, ".res_payload"}, res_payload, 0);
    chk({tag, ".res_timeout"}, res_timeout, 0);
    chk({tag, ".res_mismatch"}, res_mismatch, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".txn_count"}, txn_count, 0);
    chk({tag, ".stray_count"}, stray_count, 0);
  endtask

  // One transaction. Entered just after a falling edge with the DUT idle.
  // cw: cycles cmd_ready is held low; rw: WAIT cycle index of the response
  // (> TIMEOUT means none); dw: cycles res_ready is held low.
  task automatic run_txn(input int p, input int cw, input int rw, input int r,
                         input int dw, input int strays, input bit stray_done);
    int exp_pay, exp_to, exp_mm;
    for (int s = 0; s < strays; s++) begin
      chk("idle.req_ready", req_ready, 1);
      rsp_valid = 1'b1;
      add_stray();
      @(negedge clk);
      rsp_valid = 1'b0;
    end
    chk("idle.req_ready", req_ready, 1);
    chk("idle.busy", busy, 0);
    chk("idle.rsp_ready", rsp_ready, 1);
    req_valid = 1'b1;
    req_payload = WIDTH'(p);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= cw; i++) begin
      chk("send.cmd_valid", cmd_valid, 1);
      chk("send.cmd_payload", cmd_payload, p);
      chk("send.busy", busy, 1);
      chk("send.req_ready", req_ready, 0);
      chk("send.res_valid", res_valid, 0);
      cmd_ready = (i == cw);
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      chk("wait.cmd_valid", cmd_valid, 0);
      chk("wait.res_valid", res_valid, 0);
      chk("wait.busy", busy, 1);
      if (k == rw) begin
        rsp_valid = 1'b1;
        rsp_payload = WIDTH'(r);
        @(negedge clk);
        rsp_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (rw <= TIMEOUT) begin
      exp_pay = r;
      exp_to  = 0;
      exp_mm  = (r != ((2 * p) % (1 << WIDTH))) ? 1 : 0;
    end else begin
      exp_pay = 0;
      exp_to  = 1;
      exp_mm  = 0;
    end
    for (int j = 0; j <= dw; j++) begin
      chk("done.res_valid", res_valid, 1);
      chk("done.res_payload", res_payload, exp_pay);
      chk("done.res_timeout", res_timeout, exp_to);
      chk("done.res_mismatch", res_mismatch, exp_mm);
      chk("done.req_ready", req_ready, 0);
      if (j == 0 && stray_done) begin
        rsp_valid = 1'b1;
        add_stray();
      end else begin
        rsp_valid = 1'b0;
      end
      res_ready = (j == dw);
      @(negedge clk);
    end
    res_ready = 1'b0;
    rsp_valid = 1'b0;
    exp_txn = (exp_txn + 1) % 256;
    chk("post.res_valid", res_valid, 0);
    chk("post.req_ready", req_ready, 1);
    chk("post.txn_count", txn_count, exp_txn);
    chk("post.stray_count", stray_count, exp_stray);
  endtask

  initial begin
    int p, cw, rw, r, dw, pick;
    reset = 1'b1;
    req_valid = 1'b0; req_payload = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("rel.req_ready", req_ready, 1);
    chk("rel.rsp_ready", rsp_ready, 1);

    run_txn(3, 0, 0, 6, 0, 0, 0);     // minimum latency, match
    run_txn(9, 0, 0, 2, 0, 0, 0);     // 18 mod 16 -> match
    run_txn(9, 0, 0, 3, 0, 0, 0);     // mismatch
    run_txn(5, 5, 2, 10, 0, 0, 0);    // cmd_ready held off
    run_txn(7, 0, 16, 0, 0, 0, 0);    // timeout
    run_txn(2, 0, 15, 4, 0, 0, 0);    // response on the timeout cycle
    run_txn(1, 0, 1, 2, 4, 1, 1);     // strays in IDLE and DONE, res_ready held low

    for (int t = 0; t < 40; t++) begin
      p    = $urandom_range(0, 15);
      cw   = $urandom_range(0, 3);
      pick = $urandom_range(0, 9);
      rw   = (pick < 7) ? $urandom_range(0, 5) : ((pick == 7) ? TIMEOUT : TIMEOUT + 1);
      r    = $urandom_range(0, 1) ? ((2 * p) % 16) : $urandom_range(0, 15);
      dw   = $urandom_range(0, 3);
      run_txn(p, cw, rw, r, dw, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    for (int s = 0; s < 300; s++) begin
      rsp_valid = 1'b1;
      add_stray();
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    chk("sat.stray_count", stray_count, 255);
    chk("sat.res_valid", res_valid, 0);

    // Abandon a transaction in WAIT with reset.
    req_valid = 1'b1; req_payload = 4'd6;
    @(negedge clk);
    req_valid = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("abort.busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    exp_txn = 0;
    exp_stray = 0;
    #1;
    chk("abort.rel_req_ready", req_ready, 1);
    chk("abort.rel_rsp_ready", rsp_ready, 1);
    run_txn(4, 1, 3, 8, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
